// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU command sequencer:
//   - opcode encodings presented to the FPU core
//   - fpu_cmd_t : one queued command {op, a, b} (66 bits)
//   - seq_state_e : sequencer FSM states
//   - zero_div_visible() : masks the FPU's sticky zero-division flag
// ---------------------------------------------------------------------------
package fpu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } fpu_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_HOLD  = 2'b10
   } seq_state_e;

   // The FPU leaves its zero-division flag stale across non-divide ops,
   // so it only means something when the issued op was a divide.
   function automatic logic zero_div_visible(input logic [1:0] op, input logic zd);
      return (op == OP_DIV) && zd;
   endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// fpu_cmd_fifo
// Synchronous FIFO of fpu_cmd_t entries, synchronous active-low reset.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   i_push, i_data    : write request (ignored when full) and entry
//   i_pop             : read request (ignored when empty)
//   o_data            : head entry (valid when !o_empty)
//   o_full, o_empty   : occupancy flags
// Pointers wrap naturally; an extra count bit separates full from empty.
// ---------------------------------------------------------------------------
module fpu_cmd_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_push,
   input  fpu_cmd_t i_data,
   input  logic     i_pop,
   output fpu_cmd_t o_data,
   output logic     o_full,
   output logic     o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   fpu_cmd_t      r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // Storage array write port; contents need no reset since the count gates reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
// Flow-controlled front-end for an enable-gated FPU core. Commands are queued
// in fpu_cmd_fifo, issued one at a time (A/B/op/en held LATENCY cycles), and
// the sampled result is offered on a valid/ready result port.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake, cmd_a/cmd_b/cmd_op payload
//   fpu_en/fpu_a/fpu_b/fpu_op     : drive to the FPU core
//   fpu_result/fpu_zero_div       : FPU outputs
//   res_valid/res_ready           : result handshake, res_data/res_zero_div payload
//   busy                          : FSM active or commands queued
//   op_count                      : completed handshakes (FPU_SEQ_OPCOUNT_EN), else 0
// Optional feature macro: FPU_SEQ_OPCOUNT_EN
// ---------------------------------------------------------------------------
module fpu_op_sequencer
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [1:0]  cmd_op,
   output logic        fpu_en,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_op,
   input  logic [31:0] fpu_result,
   input  logic        fpu_zero_div,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_zero_div,
   output logic        busy,
   output logic [15:0] op_count
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   seq_state_e    r_state;
   seq_state_e    w_state_nxt;
   logic [CW-1:0] r_lat_cnt;
   logic          r_fpu_en;
   logic [31:0]   r_fpu_a;
   logic [31:0]   r_fpu_b;
   logic [1:0]    r_fpu_op;
   logic          r_res_valid;
   logic [31:0]   r_res_data;
   logic          r_res_zero_div;
   logic          w_pop;
   logic          w_capture;
   logic          w_release;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   fpu_cmd_t      w_cmd_in;
   fpu_cmd_t      w_head;

   assign w_cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b};

   fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (cmd_valid),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (r_lat_cnt == CNT_LAST) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               w_release   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Issue registers, latency counter and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lat_cnt      <= '0;
         r_fpu_en       <= 1'b0;
         r_fpu_a        <= 32'h0000_0000;
         r_fpu_b        <= 32'h0000_0000;
         r_fpu_op       <= 2'b00;
         r_res_valid    <= 1'b0;
         r_res_data     <= 32'h0000_0000;
         r_res_zero_div <= 1'b0;
      end else if (w_pop) begin
         r_fpu_a   <= w_head.a;
         r_fpu_b   <= w_head.b;
         r_fpu_op  <= w_head.op;
         r_fpu_en  <= 1'b1;
         r_lat_cnt <= '0;
      end else if (w_capture) begin
         r_res_data     <= fpu_result;
         r_res_zero_div <= zero_div_visible(r_fpu_op, fpu_zero_div);
         r_res_valid    <= 1'b1;
         r_fpu_en       <= 1'b0;
      end else if (w_release) begin
         r_res_valid <= 1'b0;
      end else if (r_state == ST_ISSUE) begin
         r_lat_cnt <= r_lat_cnt + CNT_ONE;
      end
   end

`ifdef FPU_SEQ_OPCOUNT_EN
   logic [15:0] r_op_count;

   // Completed-handshake counter, wraps at 16'hFFFF.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op_count <= 16'h0000;
      end else if (r_res_valid && res_ready) begin
         r_op_count <= r_op_count + 16'h0001;
      end
   end

   assign op_count = r_op_count;
`else
   assign op_count = 16'h0000;
`endif

   assign cmd_ready    = !w_fifo_full;
   assign busy         = (r_state != ST_IDLE) || !w_fifo_empty;
   assign fpu_en       = r_fpu_en;
   assign fpu_a        = r_fpu_a;
   assign fpu_b        = r_fpu_b;
   assign fpu_op       = r_fpu_op;
   assign res_valid    = r_res_valid;
   assign res_data     = r_res_data;
   assign res_zero_div = r_res_zero_div;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_sequencer
// Directed, table-driven bench for fpu_op_sequencer. A small FPU model answers
// from the vector table only once en has been held long enough, and keeps a
// stale zero-division flag across non-divide ops.
// ---------------------------------------------------------------------------
module tb_fpu_op_sequencer;

   localparam int DEPTH   = 4;
   localparam int LATENCY = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = 32'h0;
   logic [31:0] cmd_b = 32'h0;
   logic [1:0]  cmd_op = 2'b00;
   logic        fpu_en;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_result;
   logic        fpu_zero_div;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_zero_div;
   logic        busy;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   fpu_op_sequencer #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .fpu_en(fpu_en), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_result(fpu_result), .fpu_zero_div(fpu_zero_div),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero_div(res_zero_div),
      .busy(busy), .op_count(op_count)
   );

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zd;
   } vec_t;

   vec_t vecs [8];

   // FPU model: result valid after en held LATENCY-1 edges; sticky zero-div flag.
   int   en_cnt   = 0;
   logic model_zd = 1'b0;

   always @(posedge clk) begin
      if (fpu_en) en_cnt <= en_cnt + 1;
      else        en_cnt <= 0;
      if (fpu_en && fpu_op == 2'b11) model_zd <= (fpu_b[30:0] == 31'd0);
   end

   function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      for (int k = 0; k < 8; k++) begin
         if (vecs[k].op == op && vecs[k].a == a && vecs[k].b == b) return vecs[k].res;
      end
      return 32'hFFFF_FFFF;
   endfunction

   assign fpu_result   = (en_cnt >= LATENCY - 1) ? fpu_model(fpu_op, fpu_a, fpu_b) : 32'hDEAD_BEEF;
   assign fpu_zero_div = model_zd;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int last_hs  = -1;
   int exp_ops  = 0;
   bit spacing_en = 1'b0;
   int exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one cycle; inputs are final here, so a result handshake is judged now.
   task automatic tick();
      int idx;
      if (res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %h expected none", res_data);
         end else begin
            idx = exp_q.pop_front();
            chk("order_data", res_data, vecs[idx].res);
            chk("order_zd", 32'(res_zero_div), 32'(vecs[idx].zd));
            if (spacing_en && last_hs >= 0) chk("spacing", 32'(cyc - last_hs), 32'(LATENCY + 2));
         end
         last_hs = cyc;
`ifdef FPU_SEQ_OPCOUNT_EN
         exp_ops++;
`endif
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic push(input int idx);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op = vecs[idx].op;
      cmd_a  = vecs[idx].a;
      cmd_b  = vecs[idx].b;
      while (!cmd_ready && n < 100) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         chk("push_timeout", 32'(cmd_ready), 32'd1);
      end else begin
         tick();
         exp_q.push_back(idx);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!res_valid && n < bound) begin
         tick();
         n++;
      end
      if (!res_valid) chk("wait_valid_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < bound) begin
         tick();
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      vecs[0] = '{op: 2'b00, a: 32'h3F80_0000, b: 32'h4000_0000, res: 32'h4040_0000, zd: 1'b0};
      vecs[1] = '{op: 2'b11, a: 32'h3F80_0000, b: 32'h0000_0000, res: 32'h7F80_0000, zd: 1'b1};
      vecs[2] = '{op: 2'b10, a: 32'h4000_0000, b: 32'h4040_0000, res: 32'h40C0_0000, zd: 1'b0};
      vecs[3] = '{op: 2'b01, a: 32'h4040_0000, b: 32'h3F80_0000, res: 32'h4000_0000, zd: 1'b0};
      vecs[4] = '{op: 2'b11, a: 32'h40C0_0000, b: 32'h4000_0000, res: 32'h4040_0000, zd: 1'b0};
      vecs[5] = '{op: 2'b00, a: 32'h4000_0000, b: 32'h4000_0000, res: 32'h4080_0000, zd: 1'b0};
      vecs[6] = '{op: 2'b10, a: 32'h4080_0000, b: 32'h3F00_0000, res: 32'h4000_0000, zd: 1'b0};
      vecs[7] = '{op: 2'b01, a: 32'h3F80_0000, b: 32'h4000_0000, res: 32'hBF80_0000, zd: 1'b0};

      @(negedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fpu_en", 32'(fpu_en), 32'd0);
      chk("rst_fpu_a", fpu_a, 32'h0);
      chk("rst_res_data", res_data, 32'h0);
      chk("rst_op_count", 32'(op_count), 32'd0);

      // Single commands into an idle sequencer: latency, data, masked flag.
      for (int i = 0; i < 8; i++) begin
         push(i);
         n = 0;
         while (!res_valid && n < 40) begin
            tick();
            n++;
         end
         chk("latency", 32'(n), 32'(LATENCY + 1));
         chk("vec_data", res_data, vecs[i].res);
         chk("vec_zd", 32'(res_zero_div), 32'(vecs[i].zd));
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
         chk("res_valid_drop", 32'(res_valid), 32'd0);
         chk("op_count", 32'(op_count), 32'(exp_ops[15:0]));
      end

      // Backpressure: DEPTH+1 accepted, then full; result held stable.
      for (int i = 0; i < DEPTH + 1; i++) begin
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
         push(i);
      end
      chk("bp_full", 32'(cmd_ready), 32'd0);
      wait_valid(40);
      for (int k = 0; k < 6; k++) begin
         chk("hold_data", res_data, vecs[0].res);
         chk("hold_valid", 32'(res_valid), 32'd1);
         tick();
      end
      chk("bp_still_full", 32'(cmd_ready), 32'd0);
      spacing_en = 1'b1;
      last_hs = -1;
      res_ready = 1'b1;
      wait_drain(200);
      spacing_en = 1'b0;
      res_ready = 1'b0;
      chk("bp_op_count", 32'(op_count), 32'(exp_ops[15:0]));

      // Reset during ISSUE with two commands queued.
      res_ready = 1'b1;
      push(5);
      push(6);
      push(7);
      chk("pre_rst_fpu_en", 32'(fpu_en), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      exp_ops = 0;
      chk("mid_rst_fpu_en", 32'(fpu_en), 32'd0);
      chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_fpu_a", fpu_a, 32'h0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (res_valid) seen++;
         tick();
      end
      chk("no_result_after_rst", 32'(seen), 32'd0);
      chk("mid_rst_op_count", 32'(op_count), 32'd0);

      // Push and pop in the same cycle with DEPTH-1 queued.
      res_ready = 1'b0;
      push(0);
      wait_valid(40);
      push(1);
      push(2);
      push(3);
      chk("sim_pre_ready", 32'(cmd_ready), 32'd1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("sim_released", 32'(res_valid), 32'd0);
      push(4);
      chk("sim_ready_kept", 32'(cmd_ready), 32'd1);
      chk("sim_popped", 32'(fpu_en), 32'd1);
      push(5);
      chk("sim_now_full", 32'(cmd_ready), 32'd0);
      res_ready = 1'b1;
      wait_drain(200);

      // Pointer wrap over 3*DEPTH back-to-back commands.
      spacing_en = 1'b1;
      last_hs = -1;
      for (int i = 0; i < 3 * DEPTH; i++) push(i % 8);
      wait_drain(400);
      spacing_en = 1'b0;
      chk("wrap_op_count", 32'(op_count), 32'(exp_ops[15:0]));
      chk("final_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Command front-end placed directly upstream of the FPU core. It accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the FPU by driving A, B, op and en. Holds the command stable for a fixed latency, then captures the FPU result.
- Returns the result plus zero-division flag over a valid/ready output interface.
- Turns the FPU's free-running, enable-gated datapath into a flow-controlled, one-result-per-command unit.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- LATENCY, 4: cycles en/A/B/op are held before the FPU result is sampled; minimum 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  32  operand A, IEEE 754 single.
- cmd_b  input  32  operand B, IEEE 754 single.
- cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div.
- fpu_en  output  1  FPU enable.
- fpu_a  output  32  to FPU A.
- fpu_b  output  32  to FPU B.
- fpu_op  output  2  to FPU op.
- fpu_result  input  32  FPU result.
- fpu_zero_div  input  1  FPU zero_division.
- res_valid  output  1  result held for consumer.
- res_ready  input  1  consumer accepts result.
- res_data  output  32  captured result.
- res_zero_div  output  1  captured zero-division flag.
- busy  output  1  FSM not IDLE, or FIFO not empty.
- op_count  output  16  completed-op count (see Optional Feature).

Behaviour:
- Reset (rst_n low at a posedge):
  - FIFO emptied; FSM to IDLE.
  - fpu_en=0, fpu_a=0, fpu_b=0, fpu_op=0.
  - res_valid=0, res_data=0, res_zero_div=0, busy=0, op_count=0.
  - Reset mid-operation abandons the in-flight command and all queued commands. No result is emitted.
- FIFO:
  - cmd_ready = not full.
  - Push on cmd_valid&&cmd_ready.
  - Pop only in IDLE when FIFO non-empty.
  - Simultaneous push and pop when full is not possible, since cmd_ready=0.
  - Simultaneous push and pop when non-full: both happen and the count is unchanged.
  - Pointers are log2(DEPTH) bits wide and wrap naturally; an extra count bit distinguishes full from empty.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE, FIFO non-empty:
    - Pop the head into fpu_a/fpu_b/fpu_op registers.
    - Set fpu_en=1, clear the latency counter, go to ISSUE.
  - IDLE, FIFO empty: stay in IDLE, fpu_en=0.
  - ISSUE:
    - Counter increments each cycle; fpu_en and operands stay stable.
    - When counter==LATENCY-1:
      - Capture res_data<=fpu_result.
      - Capture res_zero_div<=(fpu_op==2'b11)&&fpu_zero_div; the flag is masked for non-div ops because the FPU holds a stale flag.
      - Set res_valid=1, fpu_en=0, go to HOLD.
  - HOLD:
    - res_data and res_zero_div stay stable while res_valid=1 && !res_ready.
    - On res_ready: res_valid=0, next state IDLE.
    - A queued command is popped on the following cycle, so throughput is LATENCY+2 cycles per command with res_ready tied high.
- Latency: command pushed into an empty FIFO with the FSM in IDLE → res_valid rises LATENCY+1 cycles after the push cycle.
- busy = (state!=IDLE) || FIFO non-empty.
- fpu_a/fpu_b/fpu_op keep the last issued values outside ISSUE; only fpu_en gates the FPU.

Optional Feature:
- Macro: FPU_SEQ_OPCOUNT_EN.
- Defined: op_count increments by 1, wrapping at 16'hFFFF→0, on each res_valid&&res_ready handshake. Reset to 0.
- Undefined: op_count is tied to 16'h0000 and no counter register is synthesised.
- Port list identical in both builds.

Decomposition:
- Shared package fpu_pkg:
  - Opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - Command struct typedef {op[1:0], a[31:0], b[31:0]} (66 bits).
  - FSM state enum.
- One natural sub-module: fpu_cmd_fifo, a parameterised synchronous FIFO of the command struct with push/pop/full/empty, reset by rst_n.
- The FSM, latency counter and result registers stay in the top.

Test Plan:
- Push {OP_ADD, 0x3F800000, 0x40000000}; model FPU returns 0x40400000 at cycle LATENCY → res_data=0x40400000, res_zero_div=0, res_valid rises exactly LATENCY+1 cycles after push.
- Push OP_DIV 0x3F800000 / 0x00000000 with model fpu_zero_div=1 → res_zero_div=1. Then push OP_MUL with stale fpu_zero_div=1 → res_zero_div=0, res_data=0x40C00000 for 2.0*3.0.
- Hold res_ready=0, push DEPTH+1 commands:
  - cmd_ready drops after DEPTH accepted, counting the one in flight as popped.
  - res_data stays stable.
  - Release res_ready → all results return in push order, spaced LATENCY+2 cycles apart.
- Assert rst_n=0 for one cycle while in ISSUE with 2 queued → next cycle fpu_en=0, res_valid=0, busy=0, cmd_ready=1; no result ever emitted for those commands.
- Push and pop in the same cycle with FIFO at DEPTH-1 → occupancy unchanged, cmd_ready stays 1; also cover pointer wrap-around over 3×DEPTH commands.
- FPU_SEQ_OPCOUNT_EN defined: 5 completed handshakes → op_count=5. Undefined: op_count=0 throughout.
